// File: rtl/if_id_pkg.sv
// Shared constants and types for the fetch/decode pipeline register.
// Covers the reset pc, the NOP word, stall vector bit positions and the state/action encodings.
package if_id_pkg;

  localparam int               REG_W          = 32;
  localparam logic [REG_W-1:0] CPU_RESET_ADDR = 32'h0000_1000;
  localparam logic [31:0]      INST_NOP       = 32'h0000_0013;

  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_t;

  function automatic logic misaligned(input logic [1:0] pc_lo);
    return |pc_lo;
  endfunction

endpackage

// File: rtl/if_id_sat_cnt.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
// One-cycle update latency; no flow control, reset is the only clear.
module if_id_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/if_id.sv
// IF/ID pipeline register: one-cycle latency, flush > hold > bubble > load; holds while stall_i[2:1]=2'b11.
// Optional perf counters (hold cycles, bubble+flush cycles) under IF_ID_PERF_CNT_EN.
module if_id
  import if_id_pkg::*;
#(
  parameter logic [31:0] NOP_INST = INST_NOP,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] pc_i,
  input  logic [31:0]      inst_i,
  input  logic [5:0]       stall_i,
  input  logic             flush_i,
  output logic [REG_W-1:0] pc_o,
  output logic [31:0]      inst_o,
  output logic             valid_o,
  output logic             inst_misalign_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  state_t           state_q, state_d;
  act_t             act;
  logic [REG_W-1:0] pc_q;
  logic [31:0]      inst_q;
  logic             mis_q;

  // Only the IF/ID and ID/EX stall bits matter here.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5:3], stall_i[0]};

  always_comb begin
    act = ACT_LOAD;
    if (flush_i) begin
      act = ACT_FLUSH;
    end else if (stall_i[STALL_IF_ID] && stall_i[STALL_ID_EX]) begin
      act = ACT_HOLD;
    end else if (stall_i[STALL_IF_ID]) begin
      act = ACT_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (act)
      ACT_FLUSH,
      ACT_BUBBLE: state_d = ST_EMPTY;
      ACT_LOAD:   state_d = ST_FULL;
      default:    state_d = state_q;
    endcase
  end

  always_comb begin
    valid_o = (state_q == ST_FULL);
  end

  // A misaligned pc is still loaded; decode owns the fault decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= CPU_RESET_ADDR;
      inst_q <= NOP_INST;
      mis_q  <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          pc_q   <= pc_i;
          inst_q <= NOP_INST;
          mis_q  <= 1'b0;
        end
        ACT_BUBBLE: begin
          inst_q <= NOP_INST;
          mis_q  <= 1'b0;
        end
        ACT_LOAD: begin
          pc_q   <= pc_i;
          inst_q <= inst_i;
          mis_q  <= misaligned(pc_i[1:0]);
        end
        default: ;
      endcase
    end
  end

  assign pc_o            = pc_q;
  assign inst_o          = inst_q;
  assign inst_misalign_o = mis_q;

`ifdef IF_ID_PERF_CNT_EN
  logic hold_cyc, bubble_cyc;
  assign hold_cyc   = (act == ACT_HOLD);
  assign bubble_cyc = (act == ACT_BUBBLE) || (act == ACT_FLUSH);

  if_id_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hold_cyc),
    .cnt   (stall_cnt_o)
  );

  if_id_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bubble_cyc),
    .cnt   (bubble_cnt_o)
  );
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: doc/if_id.md
Name: if_id

Overview:
- Pipeline register between instruction fetch (ifu) and decode (idu).
- Captures the fetch pc and the instruction word on each clock edge.
- Applies ctrl stall/bubble rules and a flush from later stages (trap or late redirect).
- Presents decode with a registered pc, instruction and valid bit, plus a misaligned-fetch flag for decode to raise a fault.

Parameters:
- NOP_INST, 32'h0000_0013, instruction word driven on bubble/flush/reset (addi x0,x0,0).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_i  input  `REG_BUS  fetch pc from ifu (ifu pc_o).
- inst_i  input  32  instruction word from inst_rom for pc_i.
- stall_i  input  6  ctrl stall vector: [1] = this register stalled, [2] = decode/ex boundary stalled.
- flush_i  input  1  ctrl flush; kills the held instruction.
- pc_o  output  `REG_BUS  registered pc to idu.
- inst_o  output  32  registered instruction to idu.
- valid_o  output  1  pc_o/inst_o hold a real instruction.
- inst_misalign_o  output  1  registered: pc_i[1:0] != 0 at capture.
- stall_cnt_o  output  CNT_W  hold-cycle count (only with IF_ID_PERF_CNT_EN).
- bubble_cnt_o  output  CNT_W  bubble+flush count (only with IF_ID_PERF_CNT_EN).

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc_o = `CPU_RESET_ADDR, inst_o = NOP_INST, valid_o = 0, inst_misalign_o = 0.
  - State EMPTY; counters = 0.
  - Reset asserted mid-stall discards any held instruction immediately.
- One action per cycle, evaluated at the rising edge in this priority:
  1. FLUSH: flush_i = 1. inst_o <= NOP_INST, valid_o <= 0, misalign <= 0, pc_o <= pc_i. Next state EMPTY. Wins over any stall.
  2. HOLD: stall_i[1] = 1 and stall_i[2] = 1. All outputs keep their values; state unchanged.
  3. BUBBLE: stall_i[1] = 1 and stall_i[2] = 0. inst_o <= NOP_INST, valid_o <= 0, misalign <= 0, pc_o unchanged. Next state EMPTY.
  4. LOAD: stall_i[1] = 0. pc_o <= pc_i, inst_o <= inst_i, valid_o <= 1, misalign <= |pc_i[1:0]. Next state FULL.
- States:
  - EMPTY (valid_o = 0) and FULL (valid_o = 1). valid_o is the registered state bit.
  - EMPTY+HOLD stays EMPTY; FULL+HOLD stays FULL.
- A misaligned instruction is still loaded as-is with valid_o = 1; decode decides whether to fault.
- Latency: exactly one cycle from pc_i/inst_i to pc_o/inst_o; no combinational path from input to output.
- Jump redirect from idu is not a flush. ifu drives the target pc in the same cycle, so LOAD captures the target instruction.
- stall_i[0] and stall_i[5:3] are ignored by this block.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on each HOLD cycle.
  - bubble_cnt_o increments on each BUBBLE or FLUSH cycle.
  - Both saturate at all-ones, reset to 0, and are never cleared by flush.
- Undefined: both ports remain on the module and are tied to 0; no counter flops are synthesised.

Decomposition:
- Add to defines.v: `INST_NOP 32'h0000_0013, IF_ID stall bit index constants (STALL_IF_ID = 1, STALL_ID_EX = 2), and the EMPTY/FULL state encoding.
- One sub-module is natural: sat_cnt (CNT_W-wide saturating counter with enable), instantiated twice under IF_ID_PERF_CNT_EN.

Test Plan:
- Reset release, stall_i = 0, then pc_i = 0x0, 0x4, 0x8 with inst_i = 0x00500093, 0x00108113, 0x00000013 → outputs follow one cycle later, valid_o = 1 from the first edge after reset.
- FULL with pc_o = 0x8; stall_i = 6'b000110 for 3 cycles while pc_i changes → pc_o = 0x8 held; stall_cnt_o += 3 (with macro); release → next pc_i loaded.
- stall_i = 6'b000011 for 1 cycle → inst_o = 0x00000013, valid_o = 0, pc_o unchanged; bubble_cnt_o += 1.
- flush_i = 1 together with stall_i = 6'b000110 → flush wins: valid_o = 0, inst_o = NOP, state EMPTY.
- Load pc_i = 0x102 → valid_o = 1, inst_misalign_o = 1; next load pc_i = 0x104 → inst_misalign_o = 0.
- rst_n pulled low asynchronously mid-HOLD with valid_o = 1 → valid_o = 0 and pc_o = `CPU_RESET_ADDR before the next clock edge; counters = 0.
